// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register owner and multiply/divide unit sequencer.
// Optional feature macro: HILO_DIVZERO_TRAP_EN (suppress DIV commit on divide-by-zero, pulse div_exc).
module hilo_ctrl #(
  parameter int N_BITS      = 32,
  parameter int DIV_CYCLES  = 33,
  parameter int MULT_CYCLES = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [N_BITS-1:0] op_a,
  input  logic [N_BITS-1:0] op_b,
  output logic              op_ready,
  output logic              stall,
  output logic [N_BITS-1:0] rd_data,
  output logic              rd_valid,
  output logic [N_BITS-1:0] unit_a,
  output logic [N_BITS-1:0] unit_b,
  output logic              div_start,
  output logic              mult_start,
  input  logic [N_BITS-1:0] div_hi,
  input  logic [N_BITS-1:0] div_lo,
  input  logic [N_BITS-1:0] mult_hi,
  input  logic [N_BITS-1:0] mult_lo,
  input  logic              div_zero,
  output logic [N_BITS-1:0] hi,
  output logic [N_BITS-1:0] lo,
  output logic              div_exc
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;
  localparam logic [2:0] OP_MFHI = 3'b100;
  localparam logic [2:0] OP_MFLO = 3'b101;

  typedef enum logic [1:0] {IDLE, START, WAIT, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             accept;
  logic             commit_en;
  logic             div_trap;

  assign op_ready  = (state_q == IDLE) && !flush;
  assign stall     = op_valid && !op_ready;
  assign accept    = op_valid && op_ready;
  assign commit_en = (state_q == COMMIT) && !flush;

`ifdef HILO_DIVZERO_TRAP_EN
  assign div_trap = commit_en && is_div_q && div_zero;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero;
  assign div_trap        = 1'b0;
`endif

  // Start is gated by flush so a cancelled op never launches the unit.
  assign div_start  = (state_q == START) && is_div_q && !flush;
  assign mult_start = (state_q == START) && !is_div_q && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && (op_code == OP_MULT || op_code == OP_DIV)) state_d = START;
      end
      START:   state_d = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      unit_a   <= '0;
      unit_b   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      div_exc  <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      div_exc  <= div_trap;
      if (accept) begin
        case (op_code)
          OP_MULT, OP_DIV: begin
            unit_a   <= op_a;
            unit_b   <= op_b;
            is_div_q <= op_code[0];
          end
          OP_MTHI: hi <= op_a;
          OP_MTLO: lo <= op_a;
          OP_MFHI: begin
            rd_data  <= hi;
            rd_valid <= 1'b1;
          end
          OP_MFLO: begin
            rd_data  <= lo;
            rd_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state_q == START) begin
        cnt_q <= is_div_q ? DIV_LOAD : MULT_LOAD;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit_en && !div_trap) begin
        hi <= is_div_q ? div_hi : mult_hi;
        lo <= is_div_q ? div_lo : mult_lo;
      end
    end
  end

endmodule
